// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder.
//   - funct3 encodings for RISC-V loads/stores
//   - responder FSM state type
//   - access size helper
//   - default LED register address
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [63:0] DMEM_LED_ADDR_DEFAULT = 64'h1000;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_RESP = 2'd2
  } dm_state_t;

  // Access size in bytes; funct3[1:0] selects 1/2/4/8 for both signed and
  // unsigned variants.
  function automatic logic [3:0] f3_size_bytes(input logic [2:0] f3);
    return 4'd1 << f3[1:0];
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational little-endian byte-lane helper.
//   Merges store data into a memory word and extracts/extends load data.
// Ports:
//   i_word      [Nbits-1:0]  current memory word
//   i_offset    [2:0]        byte offset within the word
//   i_funct3    [2:0]        access size / extension selector
//   i_wdata     [Nbits-1:0]  right-aligned store data
//   o_store_word[Nbits-1:0]  i_word with the addressed bytes replaced
//   o_load_data [Nbits-1:0]  addressed bytes, sign/zero extended
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int Nbits = 64
) (
  input  logic [Nbits-1:0] i_word,
  input  logic [2:0]       i_offset,
  input  logic [2:0]       i_funct3,
  input  logic [Nbits-1:0] i_wdata,
  output logic [Nbits-1:0] o_store_word,
  output logic [Nbits-1:0] o_load_data
);

  localparam int NBYTES = Nbits / 8;

  logic [5:0]       w_bit_shift;
  logic [3:0]       w_size;
  logic [15:0]      w_size_mask;
  logic [7:0]       w_byte_mask;
  logic [Nbits-1:0] w_wdata_sh;
  logic [Nbits-1:0] w_rd_sh;

  assign w_bit_shift = {i_offset, 3'b000};
  assign w_size      = f3_size_bytes(i_funct3);
  assign w_size_mask = (16'd1 << w_size) - 16'd1;
  // Lanes beyond the word are dropped; such accesses are misaligned anyway.
  assign w_byte_mask = w_size_mask[7:0] << i_offset;
  assign w_wdata_sh  = i_wdata << w_bit_shift;
  assign w_rd_sh     = i_word >> w_bit_shift;

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_lane
      assign o_store_word[8*gi +: 8] = w_byte_mask[gi] ? w_wdata_sh[8*gi +: 8]
                                                         : i_word[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    o_load_data = '0;
    case (i_funct3)
      F3_B:  o_load_data = {{(Nbits-8){w_rd_sh[7]}},   w_rd_sh[7:0]};
      F3_H:  o_load_data = {{(Nbits-16){w_rd_sh[15]}}, w_rd_sh[15:0]};
      F3_W:  o_load_data = {{(Nbits-32){w_rd_sh[31]}}, w_rd_sh[31:0]};
      F3_D:  o_load_data = w_rd_sh;
      F3_BU: o_load_data = {{(Nbits-8){1'b0}},  w_rd_sh[7:0]};
      F3_HU: o_load_data = {{(Nbits-16){1'b0}}, w_rd_sh[15:0]};
      F3_WU: o_load_data = {{(Nbits-32){1'b0}}, w_rd_sh[31:0]};
      default: o_load_data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data-memory responder.
//   valid/ready request, WAIT_CYCLES wait states, one-cycle response strobe.
//   Byte/half/word/double loads and stores with sign/zero extension and
//   alignment / range / illegal-funct3 error reporting.
// Optional feature macro: DMEM_MMIO_EN -- LED register at LED_ADDR.
// Ports:
//   clk                     clock, rising edge
//   rst                     asynchronous active-low reset
//   req_valid / req_ready   request handshake
//   req_we                  1 = store, 0 = load
//   req_addr  [Nbits-1:0]   byte address
//   req_wdata [Nbits-1:0]   right-aligned store data
//   req_funct3[2:0]         RISC-V funct3
//   rsp_valid               one-cycle response strobe
//   rsp_rdata [Nbits-1:0]   load result (0 for stores/errors)
//   rsp_err                 error flag, qualified by rsp_valid
//   led                     LED register bit 0
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int               Nbits       = 64,
  parameter int               DEPTH       = 256,
  parameter int               WAIT_CYCLES = 1,
  parameter logic [Nbits-1:0] LED_ADDR    = DMEM_LED_ADDR_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [Nbits-1:0] req_addr,
  input  logic [Nbits-1:0] req_wdata,
  input  logic [2:0]       req_funct3,
  output logic             rsp_valid,
  output logic [Nbits-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             led
);

  localparam int               AW        = $clog2(DEPTH);
  localparam logic [Nbits-1:0] MEM_BYTES = Nbits'(DEPTH * 8);
  localparam logic [3:0]       WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dm_state_t        r_state, w_state_next;
  logic [3:0]       r_wait_cnt;
  logic             r_ready;
  logic             r_rsp_valid;
  logic [Nbits-1:0] r_rsp_rdata;
  logic             r_rsp_err;
  logic             r_led;

  logic             r_we;
  logic [Nbits-1:0] r_addr;
  logic [Nbits-1:0] r_wdata;
  logic [2:0]       r_funct3;

  logic [Nbits-1:0] r_mem [DEPTH];

  logic             w_accept;
  logic             w_enter_resp;
  logic             w_cur_we;
  logic [Nbits-1:0] w_cur_addr;
  logic [Nbits-1:0] w_cur_wdata;
  logic [2:0]       w_cur_funct3;
  logic [AW-1:0]    w_idx;
  logic [2:0]       w_align_mask;
  logic             w_misaligned;
  logic             w_illegal;
  logic             w_in_mem;
  logic             w_is_led;
  logic             w_err;
  logic [Nbits-1:0] w_src_word;
  logic [Nbits-1:0] w_store_word;
  logic [Nbits-1:0] w_load_data;
  logic             w_mem_we;

  assign w_accept = req_valid && r_ready;

  // With zero wait states the response is produced at the accepting edge,
  // so the live request is used; otherwise the captured copy is used.
  assign w_cur_we     = (r_state == DM_IDLE) ? req_we     : r_we;
  assign w_cur_addr   = (r_state == DM_IDLE) ? req_addr   : r_addr;
  assign w_cur_wdata  = (r_state == DM_IDLE) ? req_wdata  : r_wdata;
  assign w_cur_funct3 = (r_state == DM_IDLE) ? req_funct3 : r_funct3;

  assign w_idx        = w_cur_addr[AW+2:3];
  assign w_align_mask = 3'(f3_size_bytes(w_cur_funct3) - 4'd1);
  assign w_misaligned = |(w_cur_addr[2:0] & w_align_mask);
  assign w_illegal    = w_cur_we ? w_cur_funct3[2] : (w_cur_funct3 == 3'b111);
  assign w_in_mem     = (w_cur_addr < MEM_BYTES);
`ifdef DMEM_MMIO_EN
  assign w_is_led     = (w_cur_addr == LED_ADDR);
  assign w_src_word   = w_is_led ? {{(Nbits-1){1'b0}}, r_led} : r_mem[w_idx];
`else
  assign w_is_led     = 1'b0;
  assign w_src_word   = r_mem[w_idx];
`endif
  assign w_err        = w_misaligned || w_illegal || (!w_in_mem && !w_is_led);

  dmem_lane_align #(
    .Nbits(Nbits)
  ) u_lane_align (
    .i_word      (w_src_word),
    .i_offset    (w_cur_addr[2:0]),
    .i_funct3    (w_cur_funct3),
    .i_wdata     (w_cur_wdata),
    .o_store_word(w_store_word),
    .o_load_data (w_load_data)
  );

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      DM_IDLE: begin
        if (w_accept) begin
          w_state_next = (WAIT_CYCLES == 0) ? DM_RESP : DM_WAIT;
        end
      end
      DM_WAIT: begin
        if (r_wait_cnt == WAIT_LAST) begin
          w_state_next = DM_RESP;
        end
      end
      DM_RESP: w_state_next = DM_IDLE;
      default: w_state_next = DM_IDLE;
    endcase
  end

  assign w_enter_resp = (r_state != DM_RESP) && (w_state_next == DM_RESP);
  assign w_mem_we     = rst && w_enter_resp && w_cur_we && !w_err && w_in_mem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= DM_IDLE;
      r_wait_cnt  <= 4'd0;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_funct3    <= 3'b000;
    end else begin
      r_state <= w_state_next;
      // Registered ready keeps it low during reset and for the whole
      // transaction, including the response cycle.
      r_ready <= (w_state_next == DM_IDLE);

      if (w_accept) begin
        r_we       <= req_we;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        r_funct3   <= req_funct3;
        r_wait_cnt <= 4'd0;
      end else if (r_state == DM_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end

      r_rsp_valid <= w_enter_resp;
      r_rsp_err   <= w_enter_resp && w_err;
      r_rsp_rdata <= (w_enter_resp && !w_err && !w_cur_we) ? w_load_data : '0;
    end
  end

  // Memory array contents are not reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= w_store_word;
    end
  end

`ifdef DMEM_MMIO_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_led <= 1'b0;
    end else if (w_enter_resp && w_cur_we && !w_err && w_is_led) begin
      r_led <= w_cur_wdata[0];
    end
  end
  assign led = r_led;
`else
  assign r_led = 1'b0;
  assign led   = 1'b0;
`endif

  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: three instances (WAIT_CYCLES = 1, 0, 3)
// checked against a byte-level reference memory through a scoreboard.
module tb_dmem_responder;

`ifdef DMEM_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  localparam int NDUT = 3;

  logic        clk;
  logic [NDUT-1:0] rst_v;
  logic [NDUT-1:0] req_valid_v, req_ready_v, req_we_v, rsp_valid_v, rsp_err_v, led_v;
  logic [63:0] req_addr_v  [NDUT];
  logic [63:0] req_wdata_v [NDUT];
  logic [2:0]  req_funct3_v[NDUT];
  logic [63:0] rsp_rdata_v [NDUT];

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  logic [7:0] mdl     [NDUT][2048];
  bit         mdl_led [NDUT];

  genvar gi;
  generate
    for (gi = 0; gi < NDUT; gi++) begin : g_dut
      dmem_responder #(
        .Nbits      (64),
        .DEPTH      (256),
        .WAIT_CYCLES((gi == 0) ? 1 : ((gi == 1) ? 0 : 3))
      ) u_dut (
        .clk       (clk),
        .rst       (rst_v[gi]),
        .req_valid (req_valid_v[gi]),
        .req_ready (req_ready_v[gi]),
        .req_we    (req_we_v[gi]),
        .req_addr  (req_addr_v[gi]),
        .req_wdata (req_wdata_v[gi]),
        .req_funct3(req_funct3_v[gi]),
        .rsp_valid (rsp_valid_v[gi]),
        .rsp_rdata (rsp_rdata_v[gi]),
        .rsp_err   (rsp_err_v[gi]),
        .led       (led_v[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int wait_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: byte-addressed memory plus LED bit.
  task automatic model_eval(input int k, input bit we, input logic [63:0] addr,
                            input logic [2:0] f3, output logic [63:0] rd, output logic err);
    int  sz;
    bit  is_led;
    logic [63:0] raw;
    sz     = 1 << f3[1:0];
    is_led = MMIO && (addr == 64'h1000);
    err    = (we ? f3[2] : (f3 == 3'b111)) || ((addr % sz) != 0) ||
             ((addr >= 64'd2048) && !is_led);
    rd  = '0;
    raw = '0;
    if (!err && !we) begin
      for (int i = 0; i < sz; i++) begin
        if (is_led) raw[8*i +: 8] = (i == 0) ? {7'b0, mdl_led[k]} : 8'h00;
        else        raw[8*i +: 8] = mdl[k][int'(addr) + i];
      end
      for (int j = 8*sz; j < 64; j++) raw[j] = f3[2] ? 1'b0 : raw[8*sz-1];
      rd = raw;
    end
  endtask

  task automatic model_commit(input int k, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [2:0] f3);
    int sz;
    sz = 1 << f3[1:0];
    if (MMIO && addr == 64'h1000) mdl_led[k] = wdata[0];
    else for (int i = 0; i < sz; i++) mdl[k][int'(addr) + i] = wdata[8*i +: 8];
  endtask

  task automatic do_req(input int k, input bit we, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [2:0] f3);
    exp_t e;
    exp_t got_e;
    int   n;
    int   cyc;
    model_eval(k, we, addr, f3, e.rdata, e.err);
    sb_q.push_back(e);
    @(negedge clk);
    n = 0;
    while (!req_ready_v[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_before", {63'b0, req_ready_v[k]}, 64'd1);
    req_valid_v[k]  = 1'b1;
    req_we_v[k]     = we;
    req_addr_v[k]   = addr;
    req_wdata_v[k]  = wdata;
    req_funct3_v[k] = f3;
    @(posedge clk);
    #1;
    // Scramble inputs: the captured request must be used.
    req_valid_v[k]  = 1'b0;
    req_we_v[k]     = ~we;
    req_addr_v[k]   = {$urandom, $urandom};
    req_wdata_v[k]  = {$urandom, $urandom};
    req_funct3_v[k] = 3'($urandom);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!rsp_valid_v[k] && cyc < 40);
    chk("latency", 64'(cyc), 64'(wait_of(k) + 1));
    if (rsp_valid_v[k]) begin
      got_e = sb_q.pop_front();
      chk("rsp_rdata", rsp_rdata_v[k], got_e.rdata);
      chk("rsp_err", {63'b0, rsp_err_v[k]}, {63'b0, got_e.err});
      chk("req_ready_in_resp", {63'b0, req_ready_v[k]}, 64'd0);
      $display("txn dut%0d we=%0d f3=%0d addr=%h wdata=%h rdata=%h err=%0d",
               k, we, f3, addr, wdata, rsp_rdata_v[k], rsp_err_v[k]);
      if (we && !got_e.err) model_commit(k, addr, wdata, f3);
    end else begin
      void'(sb_q.pop_front());
    end
    @(negedge clk);
    chk("rsp_one_cycle", {63'b0, rsp_valid_v[k]}, 64'd0);
    chk("req_ready_after", {63'b0, req_ready_v[k]}, 64'd1);
  endtask

  initial begin
    bit seen;
    logic [63:0] a;
    rst_v       = '0;
    req_valid_v = '0;
    req_we_v    = '0;
    for (int k = 0; k < NDUT; k++) begin
      req_addr_v[k]   = '0;
      req_wdata_v[k]  = '0;
      req_funct3_v[k] = '0;
      mdl_led[k]      = 1'b0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      chk("rst_ready", {63'b0, req_ready_v[k]}, 64'd0);
      chk("rst_rsp_valid", {63'b0, rsp_valid_v[k]}, 64'd0);
      chk("rst_rdata", rsp_rdata_v[k], 64'd0);
      chk("rst_err", {63'b0, rsp_err_v[k]}, 64'd0);
      chk("rst_led", {63'b0, led_v[k]}, 64'd0);
    end
    rst_v = '1;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) chk("ready_after_rst", {63'b0, req_ready_v[k]}, 64'd1);

    // Basic store/load, byte lanes, extension (WAIT_CYCLES=1)
    do_req(0, 1, 64'h10, 64'h8877665544332211, 3'b011);
    do_req(0, 0, 64'h10, 64'h0, 3'b011);
    do_req(0, 1, 64'h13, 64'h00000000000000F0, 3'b000);
    do_req(0, 0, 64'h13, 64'h0, 3'b000);
    do_req(0, 0, 64'h13, 64'h0, 3'b100);
    do_req(0, 0, 64'h10, 64'h0, 3'b011);
    // Misalignment
    do_req(0, 0, 64'h12, 64'h0, 3'b010);
    do_req(0, 1, 64'h11, 64'hFFFF, 3'b001);
    do_req(0, 0, 64'h10, 64'h0, 3'b011);
    // Range and illegal funct3
    do_req(0, 0, 64'h800, 64'h0, 3'b011);
    do_req(0, 0, 64'h10, 64'h0, 3'b111);
    do_req(0, 1, 64'h10, 64'hDEADBEEF, 3'b100);
    do_req(0, 0, 64'h10, 64'h0, 3'b011);
    do_req(0, 1, 64'h7F8, 64'h0123456789ABCDEF, 3'b011);
    do_req(0, 0, 64'h7FE, 64'h0, 3'b001);
    // LED register
    do_req(0, 1, 64'h1000, 64'h01, 3'b000);
    do_req(0, 0, 64'h1000, 64'h0, 3'b100);
    do_req(0, 1, 64'h1001, 64'h01, 3'b000);
    chk("led", {63'b0, led_v[0]}, {63'b0, mdl_led[0]});

    // WAIT_CYCLES=0: fill a region then mix random accesses
    for (int w = 0; w < 8; w++)
      do_req(1, 1, 64'(w * 8), {$urandom, $urandom}, 3'b011);
    for (int t = 0; t < 24; t++) begin
      a = 64'($urandom_range(0, 63));
      do_req(1, 1'($urandom), a, {$urandom, $urandom}, 3'($urandom));
    end

    // Mid-operation reset (WAIT_CYCLES=3)
    do_req(2, 1, 64'h20, 64'hA5A55A5A01234567, 3'b011);
    @(negedge clk);
    req_valid_v[2]  = 1'b1;
    req_we_v[2]     = 1'b1;
    req_addr_v[2]   = 64'h20;
    req_wdata_v[2]  = 64'h1;
    req_funct3_v[2] = 3'b011;
    @(posedge clk);
    #1;
    req_valid_v[2] = 1'b0;
    @(negedge clk);
    rst_v[2] = 1'b0;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen |= rsp_valid_v[2];
    end
    chk("midrst_ready", {63'b0, req_ready_v[2]}, 64'd0);
    rst_v[2] = 1'b1;
    repeat (6) begin
      @(negedge clk);
      seen |= rsp_valid_v[2];
    end
    chk("midrst_no_rsp", {63'b0, seen}, 64'd0);
    do_req(2, 0, 64'h20, 64'h0, 3'b011);
    do_req(2, 0, 64'h24, 64'h0, 3'b101);

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
